// File: rtl/window3x3_stream_if.sv
// Pixel-in / window-out stream bundle for window3x3_stream.
// out_sum is present only when WIN_SUM_EN is defined.
interface window3x3_stream_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  in_sof;
    logic                  out_valid;
    logic                  out_ready;
    logic [9*DATA_W-1:0]   out_win;
    logic                  out_last;
`ifdef WIN_SUM_EN
    logic [DATA_W+3:0]     out_sum;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_win, out_last, out_sum
    );
    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_win, out_last, out_sum
    );
`else
    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_win, out_last
    );
    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_win, out_last
    );
`endif
endinterface

// File: rtl/window3x3_stream.sv
// Streaming 3x3 window generator: two line buffers plus two column stages.
// Optional registered window sum on out_sum when WIN_SUM_EN is defined.
module window3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    window3x3_stream_if.slave s_bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = 9 * DATA_W;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic [CW-1:0]     w_col_nxt;
    logic [RW-1:0]     w_row_nxt;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_produce;
    logic              w_last;

    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_mid;
    logic [DATA_W-1:0] w_bot;

    logic [DATA_W-1:0] r_s1_top, r_s1_mid, r_s1_bot;
    logic [DATA_W-1:0] r_s2_top, r_s2_mid, r_s2_bot;

    logic [WW-1:0]     w_win;
    logic [WW-1:0]     r_win;
    logic              r_valid;
    logic              r_last;

    assign w_in_ready       = !r_valid || s_bus.out_ready;
    assign w_accept         = s_bus.in_valid && w_in_ready;
    assign s_bus.in_ready   = w_in_ready;
    assign s_bus.out_valid  = r_valid;
    assign s_bus.out_win    = r_win;
    assign s_bus.out_last   = r_last;

    // in_sof overrides the tracked position so the pixel lands at (0,0)
    always_comb begin
        w_col = s_bus.in_sof ? '0 : r_col;
        w_row = s_bus.in_sof ? '0 : r_row;
    end

    always_comb begin
        w_top     = r_lb0[w_col];
        w_mid     = r_lb1[w_col];
        w_bot     = s_bus.in_data;
        w_produce = w_accept && (w_row >= ROW_TWO) && (w_col >= COL_TWO);
        w_last    = (w_row == LAST_ROW) && (w_col == LAST_COL);
    end

    always_comb begin
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col == LAST_COL) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
        end
    end

    // k = 3*row_offset + col_offset, k0 at the LSBs
    always_comb begin
        w_win = {w_bot, r_s1_bot, r_s2_bot,
                 w_mid, r_s1_mid, r_s2_mid,
                 w_top, r_s1_top, r_s2_top};
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[w_col] <= w_mid;
            r_lb1[w_col] <= s_bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_s1_top <= '0;
            r_s1_mid <= '0;
            r_s1_bot <= '0;
            r_s2_top <= '0;
            r_s2_mid <= '0;
            r_s2_bot <= '0;
        end else if (w_accept) begin
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_s1_top <= w_top;
            r_s1_mid <= w_mid;
            r_s1_bot <= w_bot;
            r_s2_top <= r_s1_top;
            r_s2_mid <= r_s1_mid;
            r_s2_bot <= r_s1_bot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_win   <= '0;
            r_last  <= 1'b0;
        end else if (w_produce) begin
            r_valid <= 1'b1;
            r_win   <= w_win;
            r_last  <= w_last;
        end else if (s_bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef WIN_SUM_EN
    logic [DATA_W+3:0] w_sum;
    logic [DATA_W+3:0] r_sum;

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            w_sum = w_sum + (DATA_W+4)'(w_win[k*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_produce) begin
            r_sum <= w_sum;
        end
    end

    assign s_bus.out_sum = r_sum;
`endif

endmodule

// File: tb/tb_window3x3_stream.sv
// Self-checking bench for window3x3_stream: frame-array reference model,
// random data/handshake, directed frame, sof-resync and mid-frame reset cases.
module tb_window3x3_stream;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int WW     = 9 * DATA_W;
    localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window3x3_stream_if #(.DATA_W(DATA_W)) bus ();

    window3x3_stream #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    // reference model: the frame as a 2-D array plus the output register
    int          img [IMG_H][IMG_W];
    int          m_row, m_col;
    bit          m_valid, m_last;
    logic [WW-1:0] m_win;
    int          m_sum;
    int          m_wr, m_wc;

    int n_checks, n_pass;
    int dut_wins;
    bit pat_mode, ff_mode;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit sof,
                         input bit rdy, input bit rst, output bit acc);
        bit exp_rdy;
        bit prod;
        int r, c;
        @(negedge clk);
        rst_n         = !rst;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sof    = sof;
        bus.out_ready = rdy;
        #1;
        exp_rdy = !m_valid || rdy;
        check("out_valid", 128'(bus.out_valid), 128'(m_valid));
        check("in_ready",  128'(bus.in_ready),  128'(exp_rdy));
        check("out_win",   128'(bus.out_win),   128'(m_win));
        check("out_last",  128'(bus.out_last),  128'(m_last));
`ifdef WIN_SUM_EN
        check("out_sum",   128'(bus.out_sum),   128'(m_sum));
`endif
        if (bus.out_valid === 1'b1 && rdy) dut_wins++;
        if (m_valid && pat_mode) begin
            if (m_wr == 2 && m_wc == 2) begin
                check("first_k0", 128'(bus.out_win[0*DATA_W +: DATA_W]), 128'h00);
                check("first_k4", 128'(bus.out_win[4*DATA_W +: DATA_W]), 128'h11);
                check("first_k8", 128'(bus.out_win[8*DATA_W +: DATA_W]), 128'h22);
`ifdef WIN_SUM_EN
                check("first_sum", 128'(bus.out_sum), 128'd153);
`endif
            end
            if (m_wr == 3 && m_wc == 2) begin
                check("rowb_k0", 128'(bus.out_win[0*DATA_W +: DATA_W]), 128'h10);
                check("rowb_k8", 128'(bus.out_win[8*DATA_W +: DATA_W]), 128'h32);
            end
            if (m_wr == IMG_H-1 && m_wc == IMG_W-1) begin
                check("last_k0",   128'(bus.out_win[0*DATA_W +: DATA_W]), 128'h35);
                check("last_k8",   128'(bus.out_win[8*DATA_W +: DATA_W]), 128'h57);
                check("last_flag", 128'(bus.out_last), 128'd1);
            end
        end
`ifdef WIN_SUM_EN
        if (m_valid && ff_mode) check("ff_sum", 128'(bus.out_sum), 128'd2295);
`endif
        acc = v && exp_rdy && !rst;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_last = 0; m_win = '0; m_sum = 0;
            m_row = 0; m_col = 0;
        end else begin
            prod = 0;
            if (acc) begin
                r = sof ? 0 : m_row;
                c = sof ? 0 : m_col;
                img[r][c] = int'(d);
                if (r >= 2 && c >= 2) begin
                    prod  = 1;
                    m_sum = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) begin
                            m_win[(3*i+j)*DATA_W +: DATA_W] = DATA_W'(img[r-2+i][c-2+j]);
                            m_sum += img[r-2+i][c-2+j];
                        end
                    m_last = (r == IMG_H-1) && (c == IMG_W-1);
                    m_wr = r;
                    m_wc = c;
                end
                if (c == IMG_W-1) begin
                    m_col = 0;
                    m_row = (r == IMG_H-1) ? 0 : r + 1;
                end else begin
                    m_col = c + 1;
                    m_row = r;
                end
            end
            if (prod) m_valid = 1;
            else if (rdy) m_valid = 0;
        end
    endtask

    // mode 0: row*16+col, 1: random, 2: all ones
    task automatic feed(input int r, input int c, input bit sof, input int mode, input bit stall);
        logic [DATA_W-1:0] d;
        bit acc, v, rdy;
        int tries;
        d = (mode == 0) ? DATA_W'(r*16 + c) : (mode == 1) ? DATA_W'($urandom) : '1;
        acc = 0;
        tries = 0;
        while (!acc && tries < 40) begin
            v   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (tries > 30) begin v = 1; rdy = 1; end
            cycle(v, d, sof, rdy, 1'b0, acc);
            tries++;
        end
    endtask

    task automatic frame(input int mode, input bit stall, input bit sof0);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                feed(r, c, sof0 && r == 0 && c == 0, mode, stall);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        n_checks = 0; n_pass = 0; dut_wins = 0;
        pat_mode = 0; ff_mode = 0;
        m_row = 0; m_col = 0; m_valid = 0; m_last = 0; m_win = '0; m_sum = 0;
        m_wr = 0; m_wc = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_sof = 0; bus.out_ready = 1;

        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
        idle(1);

        pat_mode = 1;
        dut_wins = 0;
        frame(0, 1'b0, 1'b1);
        idle(3);
        check("wins_clean", 128'(dut_wins), 128'(NWIN));

        dut_wins = 0;
        frame(0, 1'b1, 1'b1);
        idle(3);
        check("wins_stall", 128'(dut_wins), 128'(NWIN));

        pat_mode = 0;
        dut_wins = 0;
        frame(1, 1'b1, 1'b1);
        idle(3);
        check("wins_random", 128'(dut_wins), 128'(NWIN));

        // partial frame up to (3,3), then resync with in_sof at (3,4)
        pat_mode = 1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < IMG_W; c++)
                if (r < 3 || c < 4) feed(r, c, 1'b0, 0, 1'b0);
        idle(3);
        dut_wins = 0;
        frame(0, 1'b0, 1'b1);
        idle(3);
        check("wins_sof", 128'(dut_wins), 128'(NWIN));

        // reset one cycle after (2,5), window held under backpressure
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < IMG_W; c++)
                if (r < 2 || c < 6) feed(r, c, 1'b0, 0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        dut_wins = 0;
        frame(0, 1'b0, 1'b0);
        idle(3);
        check("wins_reset", 128'(dut_wins), 128'(NWIN));

        pat_mode = 0;
        ff_mode = 1;
        dut_wins = 0;
        frame(2, 1'b1, 1'b1);
        idle(3);
        check("wins_ff", 128'(dut_wins), 128'(NWIN));
        ff_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
